plus_k_iter: RTL and testbench

PLUS_K_ITER -- requirements
Module: plus_k_iter

---
 rtl/plus_k_iter_if.sv | 26 ++
 rtl/plus_k_iter.sv | 96 +++++++++
 tb/tb_plus_k_iter.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/plus_k_iter_if.sv
// Operand/result handshake bundle for plus_k_iter.
// The master side offers operands and consumes results; the slave side is the block.
interface plus_k_iter_if #(
    parameter int W  = 3,
    parameter int RW = 4
);
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic [RW-1:0] in_reps;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic          out_ovf;
    logic          busy;

    modport master (
        output in_valid, in_data, in_reps, out_ready,
        input  in_ready, out_valid, out_data, out_ovf, busy
    );

    modport slave (
        input  in_valid, in_data, in_reps, out_ready,
        output in_ready, out_valid, out_data, out_ovf, busy
    );
endinterface

// File: rtl/plus_k_iter.sv
// Iterative "add K, N times" unit with wrap or saturate overflow handling.
// One addition per clock in BUSY; the result is held in DONE until the consumer takes it.
module plus_k_iter #(
    parameter int              W   = 3,
    parameter longint unsigned K   = 3,
    parameter int              RW  = 4,
    parameter bit              SAT = 1'b0
) (
    input logic          clk,
    input logic          rst,
    plus_k_iter_if.slave bus
);
    localparam longint unsigned MAXV = (longint'(1) << W) - 1;

    generate
        if (W < 2 || W > 32 || K > MAXV) begin : g_bad_param
            $error("plus_k_iter: W must be 2..32 and K must fit in W bits");
        end
    endgenerate

    localparam logic [W:0]   K_EXT = (W+1)'(K);
    localparam logic [W-1:0] ALL1  = '1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t        state, state_nxt;
    logic [W-1:0]  acc, acc_nxt;
    logic [RW-1:0] cnt, cnt_nxt;
    logic          ovf, ovf_nxt;
    logic [W:0]    sum;

    // Carry-out of the widened sum is the overflow flag for this iteration.
    function automatic logic [W-1:0] sat_step(input logic [W:0] s);
        if (s[W] && SAT)
            return ALL1;
        return s[W-1:0];
    endfunction

    assign sum = {1'b0, acc} + K_EXT;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
            cnt <= '0;
            ovf <= 1'b0;
        end else begin
            acc <= acc_nxt;
            cnt <= cnt_nxt;
            ovf <= ovf_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        cnt_nxt   = cnt;
        ovf_nxt   = ovf;
        case (state)
            IDLE: begin
                if (bus.in_valid) begin
                    acc_nxt   = bus.in_data;
                    cnt_nxt   = bus.in_reps;
                    ovf_nxt   = 1'b0;
                    state_nxt = (bus.in_reps == '0) ? DONE : BUSY;
                end
            end
            BUSY: begin
                acc_nxt = sat_step(sum);
                cnt_nxt = cnt - RW'(1);
                if (sum[W])
                    ovf_nxt = 1'b1;
                if (cnt == RW'(1))
                    state_nxt = DONE;
            end
            DONE: begin
                if (bus.out_ready)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake outputs decode the state only; data outputs expose the registers directly.
    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.busy      = (state != IDLE);
    assign bus.out_data  = acc;
    assign bus.out_ovf   = ovf;
endmodule

// File: tb/tb_plus_k_iter.sv
// Bench for plus_k_iter: four instances covering wrap, saturate, wide and max-count setups,
// driven by directed steps then random operands checked against an arithmetic model.
module tb_plus_k_iter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic        iv   [4];
    logic [31:0] id   [4];
    logic [3:0]  irp  [4];
    logic        ordy [4];
    logic        ov   [4];
    logic        ir   [4];
    logic        bz   [4];
    logic        ovfo [4];
    logic [31:0] od   [4];

    plus_k_iter_if #(.W(3), .RW(4)) b0 ();
    plus_k_iter_if #(.W(3), .RW(4)) b1 ();
    plus_k_iter_if #(.W(8), .RW(4)) b2 ();
    plus_k_iter_if #(.W(4), .RW(4)) b3 ();

    plus_k_iter #(.W(3), .K(3), .RW(4), .SAT(1'b0)) u0 (.clk(clk), .rst(rst), .bus(b0.slave));
    plus_k_iter #(.W(3), .K(3), .RW(4), .SAT(1'b1)) u1 (.clk(clk), .rst(rst), .bus(b1.slave));
    plus_k_iter #(.W(8), .K(5), .RW(4), .SAT(1'b0)) u2 (.clk(clk), .rst(rst), .bus(b2.slave));
    plus_k_iter #(.W(4), .K(1), .RW(4), .SAT(1'b0)) u3 (.clk(clk), .rst(rst), .bus(b3.slave));

    assign b0.in_valid = iv[0]; assign b0.in_data = id[0][2:0]; assign b0.in_reps = irp[0]; assign b0.out_ready = ordy[0];
    assign b1.in_valid = iv[1]; assign b1.in_data = id[1][2:0]; assign b1.in_reps = irp[1]; assign b1.out_ready = ordy[1];
    assign b2.in_valid = iv[2]; assign b2.in_data = id[2][7:0]; assign b2.in_reps = irp[2]; assign b2.out_ready = ordy[2];
    assign b3.in_valid = iv[3]; assign b3.in_data = id[3][3:0]; assign b3.in_reps = irp[3]; assign b3.out_ready = ordy[3];

    assign ov[0] = b0.out_valid; assign ir[0] = b0.in_ready; assign bz[0] = b0.busy; assign ovfo[0] = b0.out_ovf; assign od[0] = 32'(b0.out_data);
    assign ov[1] = b1.out_valid; assign ir[1] = b1.in_ready; assign bz[1] = b1.busy; assign ovfo[1] = b1.out_ovf; assign od[1] = 32'(b1.out_data);
    assign ov[2] = b2.out_valid; assign ir[2] = b2.in_ready; assign bz[2] = b2.busy; assign ovfo[2] = b2.out_ovf; assign od[2] = 32'(b2.out_data);
    assign ov[3] = b3.out_valid; assign ir[3] = b3.in_ready; assign bz[3] = b3.busy; assign ovfo[3] = b3.out_ovf; assign od[3] = 32'(b3.out_data);

    function automatic int pw(input int i);
        case (i)
            2: return 8;
            3: return 4;
            default: return 3;
        endcase
    endfunction

    function automatic int pk(input int i);
        case (i)
            2: return 5;
            3: return 1;
            default: return 3;
        endcase
    endfunction

    function automatic bit psat(input int i);
        return (i == 1);
    endfunction

    // Reference: repeat "add K" in plain integer arithmetic and note any result above 2^W-1.
    task automatic model(input int i, input longint data, input int reps,
                         output longint res, output bit o);
        longint maxv;
        longint a;
        maxv = (longint'(1) << pw(i)) - 1;
        a    = data & maxv;
        o    = 1'b0;
        for (int r = 0; r < reps; r++) begin
            a = a + pk(i);
            if (a > maxv) begin
                o = 1'b1;
                a = psat(i) ? maxv : a - (maxv + 1);
            end
        end
        res = a;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One full transaction: offer, count edges to out_valid, hold under backpressure, accept.
    task automatic run(input int i, input int data, input int reps,
                       input int exp_d, input bit exp_o, input int hold);
        int n;
        int busy_cnt;
        logic [31:0] held_d;
        logic        held_o;
        n = 0;
        while (!ir[i] && n < 40) begin
            @(posedge clk); #1; n++;
        end
        chk("in_ready_before_offer", 32'(ir[i]), 32'd1);
        @(negedge clk);
        iv[i] = 1'b1; id[i] = 32'(data); irp[i] = 4'(reps);
        @(posedge clk); #1;
        iv[i] = 1'b0;
        n = 0; busy_cnt = 0;
        while (!ov[i] && n < 40) begin
            if (bz[i]) busy_cnt++;
            chk("in_ready_low_while_busy", 32'(ir[i]), 32'd0);
            @(posedge clk); #1; n++;
        end
        chk("latency_edges", 32'(n), 32'(reps));
        chk("busy_cycles", 32'(busy_cnt), 32'(reps));
        chk("out_valid", 32'(ov[i]), 32'd1);
        chk("out_data", od[i], 32'(exp_d));
        chk("out_ovf", 32'(ovfo[i]), 32'(exp_o));
        held_d = od[i]; held_o = ovfo[i];
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            iv[i] = h[0]; id[i] = $urandom; irp[i] = 4'($urandom);
            @(posedge clk); #1;
            chk("bp_out_valid", 32'(ov[i]), 32'd1);
            chk("bp_in_ready", 32'(ir[i]), 32'd0);
            chk("bp_out_data", od[i], held_d);
            chk("bp_out_ovf", 32'(ovfo[i]), 32'(held_o));
        end
        @(negedge clk);
        iv[i] = 1'b0; ordy[i] = 1'b1;
        @(posedge clk); #1;
        ordy[i] = 1'b0;
        chk("back_to_idle_ready", 32'(ir[i]), 32'd1);
        chk("back_to_idle_valid", 32'(ov[i]), 32'd0);
    endtask

    initial begin
        longint exp_res;
        bit     exp_o;
        int     d, r;
        for (int i = 0; i < 4; i++) begin
            iv[i] = 1'b0; id[i] = '0; irp[i] = '0; ordy[i] = 1'b0;
        end
        #2;
        for (int i = 0; i < 4; i++) begin
            chk("reset_in_ready", 32'(ir[i]), 32'd1);
            chk("reset_out_valid", 32'(ov[i]), 32'd0);
            chk("reset_out_data", od[i], 32'd0);
            chk("reset_out_ovf", 32'(ovfo[i]), 32'd0);
            chk("reset_busy", 32'(bz[i]), 32'd0);
        end
        @(negedge clk); @(negedge clk);
        rst = 1'b0;

        // Wrap sweep, W=3 K=3, one iteration each.
        for (int v = 0; v < 8; v++)
            run(0, v, 1, (v + 3) % 8, v >= 5, v % 3);

        // Saturating instance.
        run(1, 6, 2, 7, 1'b1, 2);
        run(1, 1, 2, 7, 1'b0, 0);

        // W=8 K=5: multi-wrap and zero-iteration pass-through.
        run(2, 250, 3, 9, 1'b1, 0);
        run(2, 7, 0, 7, 1'b0, 1);

        // Backpressure for 10 cycles with in_valid pulses.
        run(2, 200, 15, 19, 1'b1, 10);

        // Maximum count on W=4 K=1.
        run(3, 0, 15, 15, 1'b0, 0);

        // Asynchronous reset in the middle of a 15-iteration run.
        @(negedge clk);
        iv[0] = 1'b1; id[0] = 32'd2; irp[0] = 4'd15;
        @(posedge clk); #1;
        iv[0] = 1'b0;
        repeat (4) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("midrst_in_ready", 32'(ir[0]), 32'd1);
        chk("midrst_out_valid", 32'(ov[0]), 32'd0);
        chk("midrst_out_data", od[0], 32'd0);
        chk("midrst_out_ovf", 32'(ovfo[0]), 32'd0);
        chk("midrst_busy", 32'(bz[0]), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            chk("post_rst_no_valid", 32'(ov[0]), 32'd0);
        end
        run(0, 4, 2, 2, 1'b1, 0);

        // Random operands against the arithmetic model.
        for (int t = 0; t < 60; t++) begin
            int i;
            i = $urandom_range(3, 0);
            d = $urandom;
            r = $urandom_range(15, 0);
            model(i, longint'(d) & 64'hFFFF_FFFF, r, exp_res, exp_o);
            run(i, d, r, int'(exp_res), exp_o, $urandom_range(3, 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
